onehot_scan_monitor: RTL

- Receive-side companion to the one-hot row/column select shifter in the pixel readout path.
- Samples the one-hot select bus on each advance strobe and encodes it to a binary index for the ADC/readout logic.
- Checks that the bus steps exactly one position per advance, with wrap from LENGTH-1 to 0.
- Counts completed scans (frames) and raises sticky error flags on malformed or out-of-sequence selects.

---
 rtl/onehot_scan_monitor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/onehot_scan_monitor.sv
// onehot_scan_monitor: encodes and sequence-checks the one-hot row/column select bus.
// Optional stall timeout is enabled with `define SCAN_MONITOR_TIMEOUT_EN.
module onehot_scan_monitor #(
  parameter int LENGTH         = 4,
  parameter int IDX_W          = $clog2(LENGTH),
  parameter int FRAME_CNT_W    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [LENGTH-1:0]      sel_in,
  input  logic                   err_clear,
  output logic [IDX_W-1:0]       index_out,
  output logic                   index_valid,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   onehot_err,
  output logic                   seq_err,
  output logic                   stall_err
);

  typedef enum logic {SYNC, TRACK} state_t;

  state_t                 r_state;
  logic [LENGTH-1:0]      r_exp;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_valid;
  logic                   r_fd;
  logic [FRAME_CNT_W-1:0] r_fc;
  logic                   r_oh_err;
  logic                   r_seq_err;
  logic                   r_stall_err;

  logic                   w_onehot;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_last;

  // X/Z on any bit makes the sample invalid in simulation
  assign w_onehot = (sel_in != '0) &&
                    ((sel_in & (sel_in - LENGTH'(1))) == '0) &&
                    !$isunknown(sel_in);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < LENGTH; i++)
      if (sel_in[i]) w_idx = IDX_W'(i);
  end

  assign w_last = (w_idx == IDX_W'(LENGTH-1));

`ifdef SCAN_MONITOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SYNC;
      r_exp       <= LENGTH'(1);
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_fd        <= 1'b0;
      r_fc        <= '0;
      r_oh_err    <= 1'b0;
      r_seq_err   <= 1'b0;
      r_stall_err <= 1'b0;
`ifdef SCAN_MONITOR_TIMEOUT_EN
      r_to        <= '0;
`endif
    end else begin
      r_fd <= 1'b0;
      if (err_clear) begin
        r_oh_err    <= 1'b0;
        r_seq_err   <= 1'b0;
        r_stall_err <= 1'b0;
      end
      if (sample_en) begin
        if (!w_onehot) begin
          r_oh_err <= 1'b1;
          r_valid  <= 1'b0;
          r_state  <= SYNC;
        end else begin
          r_idx   <= w_idx;
          r_valid <= 1'b1;
          if (r_state == TRACK && sel_in == r_exp) begin
            r_exp <= {r_exp[LENGTH-2:0], r_exp[LENGTH-1]};
            if (w_last) begin
              r_fd <= 1'b1;
              r_fc <= r_fc + FRAME_CNT_W'(1);
            end
          end else begin
            // Bit 0 always restarts tracking, from SYNC or after a mismatch
            if (r_state == TRACK) r_seq_err <= 1'b1;
            if (sel_in[0]) begin
              r_state <= TRACK;
              r_exp   <= LENGTH'(2);
            end else begin
              r_state <= SYNC;
            end
          end
        end
      end
`ifdef SCAN_MONITOR_TIMEOUT_EN
      if (sample_en || r_state != TRACK) begin
        r_to <= '0;
      end else if (r_to == TO_W'(TIMEOUT_CYCLES-1)) begin
        r_to        <= '0;
        r_stall_err <= 1'b1;
        r_state     <= SYNC;
        r_valid     <= 1'b0;
      end else begin
        r_to <= r_to + TO_W'(1);
      end
`endif
    end
  end

  assign index_out   = r_idx;
  assign index_valid = r_valid;
  assign frame_done  = r_fd;
  assign frame_count = r_fc;
  assign onehot_err  = r_oh_err;
  assign seq_err     = r_seq_err;
`ifdef SCAN_MONITOR_TIMEOUT_EN
  assign stall_err   = r_stall_err;
`else
  assign stall_err   = 1'b0;
`endif

endmodule
